// File: rtl/pipeline_halt_dumper.sv
// -----------------------------------------------------------------------------
// pipeline_halt_dumper
//
// End-of-program controller for the pipelined processor. It watches the
// decode-stage instruction stream for the halt trap word, stalls the front
// end, waits for in-flight instructions to drain, then reads a window of data
// memory one word at a time and streams each (address, data) pair out under a
// valid/ready handshake. A cycle watchdog ends runaway programs.
//
// Optional feature macro: HALT_DUMP_ON_TIMEOUT_EN
//   defined   : a watchdog expiry dumps memory exactly as a trap would
//               (timeout and done both end at 1).
//   undefined : a watchdog expiry goes straight to DONE, no memory reads.
//
// Ports:
//   clock        in   system clock, all state changes on the rising edge
//   reset        in   synchronous active-high reset, returns to RUN
//   instr_valid  in   instr carries a real decode-stage instruction
//   instr        in   decode-stage instruction word
//   halt_req     out  stall request to fetch, high in every state but RUN
//   mem_rd_en    out  one-cycle data memory read strobe
//   mem_rd_addr  out  byte address of the read
//   mem_rd_data  in   read data, valid one cycle after mem_rd_en
//   dump_valid   out  dump_addr/dump_data hold a word
//   dump_ready   in   consumer accepts the presented word
//   dump_addr    out  byte address of the presented word
//   dump_data    out  presented word
//   done         out  dump complete, sticky until reset
//   timeout      out  watchdog fired, sticky until reset
// -----------------------------------------------------------------------------
module pipeline_halt_dumper #(
   parameter int unsigned       DATA_W         = 32,
   parameter int unsigned       ADDR_W         = 32,
   parameter logic [DATA_W-1:0] TRAP_WORD      = DATA_W'(32'h4400_0300),
   parameter int unsigned       DRAIN_CYCLES   = 10,
   parameter logic [ADDR_W-1:0] DUMP_BASE      = ADDR_W'(8192),
   parameter int unsigned       DUMP_WORDS     = 10,
   parameter int unsigned       BYTES_PER_WORD = 4,
   parameter int unsigned       TIMEOUT_CYCLES = 25000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] instr,
   output logic              halt_req,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              done,
   output logic              timeout
);

   // Terminal counts; the zero cases are guarded where they are used.
   localparam logic [31:0] DRAIN_LAST   = (DRAIN_CYCLES == 0)   ? 32'd0 : 32'(DRAIN_CYCLES - 1);
   localparam logic [31:0] WORDS_LAST   = (DUMP_WORDS == 0)     ? 32'd0 : 32'(DUMP_WORDS - 1);
   localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BYTES_PER_WORD);

   typedef enum logic [2:0] {
      S_RUN   = 3'd0,
      S_DRAIN = 3'd1,
      S_READ  = 3'd2,
      S_WAIT  = 3'd3,
      S_EMIT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t            state_q;
   logic [31:0]       cyc_q;        // RUN-state cycle counter for the watchdog
   logic [31:0]       drain_q;      // cycles spent in DRAIN
   logic [31:0]       idx_q;        // index of the word currently being dumped
   logic [ADDR_W-1:0] addr_q;       // address of the next word to read
   logic              halt_req_q;
   logic              mem_rd_en_q;
   logic [ADDR_W-1:0] mem_rd_addr_q;
   logic              dump_valid_q;
   logic [ADDR_W-1:0] dump_addr_q;
   logic [DATA_W-1:0] dump_data_q;
   logic              done_q;
   logic              timeout_q;

   logic trap_hit;
   logic wd_fire;
   logic start_dump;
   logic drain_exit;

   // An invalid decode slot can never look like a trap.
   assign trap_hit = instr_valid && (instr == TRAP_WORD);
   assign wd_fire  = (TIMEOUT_CYCLES != 0) && (cyc_q == TIMEOUT_LAST);

`ifdef HALT_DUMP_ON_TIMEOUT_EN
   assign start_dump = trap_hit || wd_fire;
`else
   assign start_dump = trap_hit;
`endif

   // Leaving the drain phase: either the drain count has elapsed, or a zero
   // drain makes the RUN-state trigger edge act as the end of drain too, so
   // the first read strobe lands DRAIN_CYCLES cycles after the trigger.
   assign drain_exit = ((state_q == S_RUN) && start_dump && (DRAIN_CYCLES == 0)) ||
                       ((state_q == S_DRAIN) && (drain_q == DRAIN_LAST));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_RUN;
         cyc_q         <= 32'd0;
         drain_q       <= 32'd0;
         idx_q         <= 32'd0;
         addr_q        <= DUMP_BASE;
         halt_req_q    <= 1'b0;
         mem_rd_en_q   <= 1'b0;
         mem_rd_addr_q <= '0;
         dump_valid_q  <= 1'b0;
         dump_addr_q   <= '0;
         dump_data_q   <= '0;
         done_q        <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         // Read strobe is a single-cycle pulse unless re-armed below.
         mem_rd_en_q <= 1'b0;

         case (state_q)
            S_RUN: begin
               cyc_q <= cyc_q + 32'd1;
               if (start_dump) begin
                  // Trap has priority: a simultaneous expiry is not a timeout.
                  halt_req_q <= 1'b1;
                  state_q    <= S_DRAIN;
                  drain_q    <= 32'd0;
                  if (!trap_hit) begin
                     timeout_q <= 1'b1;
                  end
               end else if (wd_fire) begin
                  halt_req_q <= 1'b1;
                  timeout_q  <= 1'b1;
                  done_q     <= 1'b1;
                  state_q    <= S_DONE;
               end
            end

            S_DRAIN: begin
               drain_q <= drain_q + 32'd1;
            end

            S_READ: begin
               state_q <= S_WAIT;
            end

            S_WAIT: begin
               // Memory returns data in this cycle; latch it with its address.
               dump_data_q  <= mem_rd_data;
               dump_addr_q  <= mem_rd_addr_q;
               dump_valid_q <= 1'b1;
               state_q      <= S_EMIT;
            end

            S_EMIT: begin
               if (dump_ready) begin
                  dump_valid_q <= 1'b0;
                  idx_q        <= idx_q + 32'd1;
                  addr_q       <= addr_q + STRIDE;
                  if (idx_q == WORDS_LAST) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     mem_rd_en_q   <= 1'b1;
                     mem_rd_addr_q <= addr_q + STRIDE;
                     state_q       <= S_READ;
                  end
               end
            end

            S_DONE: begin
               // Idle until reset; traps are ignored.
            end

            default: begin
               state_q <= S_RUN;
            end
         endcase

         // End of drain overrides whatever the state case chose above.
         if (drain_exit) begin
            if (DUMP_WORDS == 0) begin
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end else begin
               mem_rd_en_q   <= 1'b1;
               mem_rd_addr_q <= addr_q;
               state_q       <= S_READ;
            end
         end
      end
   end

   assign halt_req    = halt_req_q;
   assign mem_rd_en   = mem_rd_en_q;
   assign mem_rd_addr = mem_rd_addr_q;
   assign dump_valid  = dump_valid_q;
   assign dump_addr   = dump_addr_q;
   assign dump_data   = dump_data_q;
   assign done        = done_q;
   assign timeout     = timeout_q;

endmodule
